// File: rtl/me_job_dispatcher.sv
// Job front-end for the modular-exponentiation core: stages word-serial operands,
// pulses one core enable, watches for done with a timeout, and streams the result back.
module me_job_dispatcher #(
  parameter int unsigned M_SIZE  = 3072,
  parameter int unsigned W       = 64,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  output logic              core_en_one_mm,
  output logic              core_en_me,
  output logic              core_en_pre_me,
  output logic [TAG_W-1:0]  core_num,
  output logic [M_SIZE-1:0] core_a,
  output logic [M_SIZE-1:0] core_e,
  input  logic              core_done,
  input  logic [M_SIZE-1:0] core_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              busy,
  output logic [CNT_W-1:0]  jobs_done,
  output logic [CNT_W-1:0]  jobs_err
);

  localparam int unsigned WORDS  = M_SIZE / W;
  localparam int unsigned BEAT_W = $clog2(2 * WORDS);
  localparam int unsigned IDX_W  = $clog2(WORDS + 1);

  localparam logic [BEAT_W-1:0] A_BEATS   = BEAT_W'(WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t              state, state_n;
  logic [1:0]          mode_q;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   word_sel;
  logic [CNT_W-1:0]    to_cnt;
  logic [IDX_W-1:0]    out_idx;
  logic [M_SIZE-1:0]   res_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_n = (cmd_mode == 2'd3) ? S_ERR : S_LOAD;
      S_LOAD:  if (in_valid && beat_cnt == LAST_BEAT) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      // done is checked first so a completion on the final allowed cycle still drains
      S_WAIT: begin
        if (core_done)              state_n = S_DRAIN;
        else if (to_cnt == TO_LAST) state_n = S_ERR;
      end
      S_DRAIN: if (out_ready && out_idx == LAST_IDX) state_n = S_IDLE;
      S_ERR:   if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = 1'b0;
    in_ready       = 1'b0;
    busy           = 1'b1;
    core_en_one_mm = 1'b0;
    core_en_me     = 1'b0;
    core_en_pre_me = 1'b0;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    out_err        = 1'b0;
    out_data       = '0;
    out_tag        = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: in_ready = 1'b1;
      S_ISSUE: begin
        core_en_one_mm = (mode_q == 2'd0);
        core_en_me     = (mode_q == 2'd1);
        core_en_pre_me = (mode_q == 2'd2);
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = res_q[W-1:0];
        out_tag   = core_num;
        out_last  = (out_idx == LAST_IDX);
      end
      S_ERR: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_err   = 1'b1;
        out_tag   = core_num;
      end
      default: ;
    endcase
  end

  // Beats 0..WORDS-1 address core_a, the rest address core_e, both LSW first.
  always_comb begin
    word_sel = beat_cnt;
    if (beat_cnt >= A_BEATS) word_sel = beat_cnt - A_BEATS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= '0;
      core_num  <= '0;
      core_a    <= '0;
      core_e    <= '0;
      beat_cnt  <= '0;
      to_cnt    <= '0;
      out_idx   <= '0;
      res_q     <= '0;
      jobs_done <= '0;
      jobs_err  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          if (cmd_valid) begin
            mode_q   <= cmd_mode;
            core_num <= cmd_tag;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            for (int unsigned i = 0; i < WORDS; i++) begin
              if (word_sel == BEAT_W'(i)) begin
                if (beat_cnt < A_BEATS) core_a[i*W +: W] <= in_data;
                else                    core_e[i*W +: W] <= in_data;
              end
            end
          end
        end
        S_ISSUE: to_cnt <= '0;
        S_WAIT: begin
          if (core_done) begin
            res_q   <= core_z;
            out_idx <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        // Result is shifted out so the current word always sits in the low slice.
        S_DRAIN: begin
          if (out_ready) begin
            res_q   <= res_q >> W;
            out_idx <= out_idx + 1'b1;
            if (out_idx == LAST_IDX) jobs_done <= jobs_done + 1'b1;
          end
        end
        S_ERR: if (out_ready) jobs_err <= jobs_err + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_me_job_dispatcher.sv
// Scoreboard bench for me_job_dispatcher: directed jobs against a behavioural modexp core
// (modulus 2^127-1), with a decoupled output monitor that pops expected words.
module tb_me_job_dispatcher;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic [3:0]   cmd_tag;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         core_en_one_mm;
  logic         core_en_me;
  logic         core_en_pre_me;
  logic [3:0]   core_num;
  logic [127:0] core_a;
  logic [127:0] core_e;
  logic         core_done;
  logic [127:0] core_z;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [3:0]   out_tag;
  logic         out_err;
  logic         busy;
  logic [15:0]  jobs_done;
  logic [15:0]  jobs_err;

  me_job_dispatcher #(
    .M_SIZE (128),
    .W      (32),
    .TAG_W  (4),
    .TIMEOUT(50),
    .CNT_W  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_tag       (cmd_tag),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .core_en_one_mm(core_en_one_mm),
    .core_en_me    (core_en_me),
    .core_en_pre_me(core_en_pre_me),
    .core_num      (core_num),
    .core_a        (core_a),
    .core_e        (core_e),
    .core_done     (core_done),
    .core_z        (core_z),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_tag       (out_tag),
    .out_err       (out_err),
    .busy          (busy),
    .jobs_done     (jobs_done),
    .jobs_err      (jobs_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  tag;
    logic        err;
    int          lat;
    logic        from_cmd;
  } exp_t;

  exp_t exp_q[$];

  int compares = 0;
  int fails    = 0;
  int cyc      = 0;
  int t_cmd    = 0;
  int t_issue  = 0;
  int pulses   = 0;

  // Job description shared with the core model and monitor (written by main only)
  logic [2:0]   exp_en;
  logic [3:0]   exp_tag;
  logic [127:0] exp_a;
  logic [127:0] exp_e;
  int           done_delay   = -1;
  int           stall_word   = -1;
  int           stall_cycles = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] modexp(input logic [127:0] a, input logic [127:0] e);
    logic [255:0] r, b, m;
    m = {128'd0, 1'b0, {127{1'b1}}};
    r = 256'd1;
    b = {128'd0, a} % m;
    for (int i = 0; i < 128; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[127:0];
  endfunction

  // Behavioural core: checks the enable pulse, then returns modexp after done_delay cycles
  initial begin : core_model
    core_done = 1'b0;
    core_z    = '0;
    forever begin
      @(negedge clk);
      if (core_en_one_mm || core_en_me || core_en_pre_me) begin
        pulses++;
        t_issue = cyc;
        chk("core_en_onehot", 128'({core_en_pre_me, core_en_me, core_en_one_mm}), 128'(exp_en));
        chk("core_num", 128'(core_num), 128'(exp_tag));
        chk("core_a", core_a, exp_a);
        chk("core_e", core_e, exp_e);
        if (done_delay >= 0) begin
          repeat (done_delay) @(negedge clk);
          core_z    = modexp(core_a, core_e);
          core_done = 1'b1;
          @(negedge clk);
          core_done = 1'b0;
          core_z    = '0;
        end
      end
    end
  end

  initial begin : monitor
    int   widx;
    int   stalled;
    exp_t x;
    widx      = 0;
    stalled   = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid !== 1'b1) begin
        out_ready = 1'b0;
      end else if (exp_q.size() == 0) begin
        chk("out_unexpected", 128'(out_valid), 128'(0));
        out_ready = 1'b1;
      end else begin
        x = exp_q[0];
        if (x.lat >= 0) begin
          chk("latency", 128'(cyc - (x.from_cmd ? t_cmd : t_issue)), 128'(x.lat));
          exp_q[0].lat = -1;
        end
        chk("out_data", 128'(out_data), 128'(x.data));
        chk("out_last", 128'(out_last), 128'(x.last));
        chk("out_tag",  128'(out_tag),  128'(x.tag));
        chk("out_err",  128'(out_err),  128'(x.err));
        if (widx == stall_word && stalled < stall_cycles) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          void'(exp_q.pop_front());
          if (x.last) begin
            widx    = 0;
            stalled = 0;
          end else begin
            widx++;
          end
        end
      end
    end
  end

  task automatic push_z(input logic [127:0] z, input logic [3:0] tag, input int lat);
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      x.data     = z[7'(i*32) +: 32];
      x.last     = (i == 3);
      x.tag      = tag;
      x.err      = 1'b0;
      x.lat      = (i == 0) ? lat : -1;
      x.from_cmd = 1'b0;
      exp_q.push_back(x);
    end
  endtask

  task automatic push_err(input logic [3:0] tag, input int lat, input logic from_cmd);
    exp_t x;
    x.data     = '0;
    x.last     = 1'b1;
    x.tag      = tag;
    x.err      = 1'b1;
    x.lat      = lat;
    x.from_cmd = from_cmd;
    exp_q.push_back(x);
  endtask

  task automatic do_cmd(input logic [1:0] mode, input logic [3:0] tag);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_tag   = tag;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_timeout", 128'(n >= 100), 128'(0));
    t_cmd = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_accept_timeout", 128'(n >= 100), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [127:0] a, input logic [127:0] e, input bit stall);
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = (i < 4) ? a[7'(i*32) +: 32] : e[7'((i-4)*32) +: 32];
      if (stall && i > 0) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
      end
      send_word(w);
    end
  endtask

  task automatic job(input logic [1:0] mode, input logic [3:0] tag, input logic [127:0] a,
                     input logic [127:0] e, input int delay, input bit in_stall);
    exp_en     = (mode == 2'd0) ? 3'b001 : (mode == 2'd1) ? 3'b010 : 3'b100;
    exp_tag    = tag;
    exp_a      = a;
    exp_e      = e;
    done_delay = delay;
    do_cmd(mode, tag);
    if (mode != 2'd3) load(a, e, in_stall);
  endtask

  task automatic wait_idle(input int exp_done, input int exp_err);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 128'(n >= 500), 128'(0));
    @(negedge clk);
    chk("jobs_done", 128'(jobs_done), 128'(exp_done));
    chk("jobs_err",  128'(jobs_err),  128'(exp_err));
  endtask

  initial begin : main
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = '0;
    cmd_tag   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_core_a",    core_a,          128'(0));
    chk("rst_jobs_done", 128'(jobs_done), 128'(0));

    // Basic one_mm: (2^32+1)^2 = 2^64 + 2^33 + 1
    push_z(128'h00000000_00000001_00000002_00000001, 4'd3, 21);
    job(2'd0, 4'd3, 128'h1_0000_0001, 128'd2, 20, 1'b0);
    wait_idle(1, 0);

    // Backpressure both sides: (3*2^32+2)^2 = 9*2^64 + 12*2^32 + 4
    stall_word   = 1;
    stall_cycles = 5;
    push_z(128'h00000000_00000009_0000000C_00000004, 4'd5, 8);
    job(2'd1, 4'd5, 128'h3_0000_0002, 128'd2, 7, 1'b1);
    wait_idle(2, 0);
    stall_word   = -1;
    stall_cycles = 0;

    // Timeout: ERR beat 51 cycles after ISSUE
    push_err(4'd9, 51, 1'b0);
    job(2'd1, 4'd9, 128'd5, 128'd3, -1, 1'b0);
    wait_idle(2, 1);

    // pre_me after timeout: 2^192 mod (2^127-1) = 2^65
    push_z(128'h00000000_00000002_00000000_00000000, 4'd10, 4);
    job(2'd2, 4'd10, 128'h1_0000_0000_0000_0000, 128'd3, 3, 1'b0);
    wait_idle(3, 1);

    // Done on the same cycle the timeout is reached: 3^5 = 243
    push_z(128'hF3, 4'd12, 51);
    job(2'd0, 4'd12, 128'd3, 128'd5, 50, 1'b0);
    wait_idle(4, 1);

    // Illegal mode: immediate ERR, staged operands untouched
    push_err(4'd7, 1, 1'b1);
    job(2'd3, 4'd7, 128'd0, 128'd0, -1, 1'b0);
    wait_idle(4, 2);
    chk("core_a_held", core_a, 128'd3);
    chk("core_e_held", core_e, 128'd5);

    // Reset mid-WAIT; the late done must be ignored
    job(2'd1, 4'd6, 128'd7, 128'd2, 30, 1'b0);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy",      128'(busy),      128'(0));
    chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_core_a",    core_a,          128'(0));
    chk("mid_rst_core_e",    core_e,          128'(0));
    chk("mid_rst_core_num",  128'(core_num),  128'(0));
    chk("mid_rst_jobs_done", 128'(jobs_done), 128'(0));
    chk("mid_rst_jobs_err",  128'(jobs_err),  128'(0));
    chk("mid_rst_en",        128'({core_en_pre_me, core_en_me, core_en_one_mm}), 128'(0));
    repeat (30) @(negedge clk);
    chk("late_done_busy",      128'(busy),      128'(0));
    chk("late_done_jobs_done", 128'(jobs_done), 128'(0));

    // Job after reset: (2^40)^3 = 2^120
    push_z(128'h01000000_00000000_00000000_00000000, 4'd1, 5);
    job(2'd0, 4'd1, 128'h100_0000_0000, 128'd3, 4, 1'b0);
    wait_idle(1, 0);

    chk("pulse_count", 128'(pulses), 128'(7));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
